// File: rtl/nios_edge_capture_in_if.sv
// Avalon-MM slave bus of the edge-capture input port plus its level interrupt.
// The master modport is the Nios data master side; the slave modport is the port.
interface nios_edge_capture_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/nios_edge_capture_in.sv
// Avalon-MM input PIO: synchronised in_port, sticky per-bit edgecapture, maskable level irq.
// Latency: readdata combinational; in_port visible after 2 clocks, edgecapture after 3.
// Backpressure: none, the slave accepts every access with zero wait states.
// Optional BIT_CLEAR_EDGE_EN: per-bit write-1-to-clear of edgecapture instead of clear-all.
module nios_edge_capture_in #(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_TYPE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_port,
    nios_edge_capture_in_if.slave bus
);
    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t       s1_q, s1_d;
    word_t       s2_q, s2_d;
    word_t       s3_q, s3_d;
    word_t       irqmask_q, irqmask_d;
    word_t       edgecap_q, edgecap_d;
    word_t       edge_det;
    logic        wr_vld;
    logic        wr_mask;
    logic        wr_ec;
    logic [31:0] rd_dat;
    logic        unused_wr;

    assign unused_wr = ^bus.writedata;

    always_comb begin
        wr_vld  = bus.chipselect && !bus.write_n;
        wr_mask = wr_vld && (bus.address == 2'd2);
        wr_ec   = wr_vld && (bus.address == 2'd3);
    end

    // s2 is the settled sample, s3 its value one clock earlier
    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = s2_q & ~s3_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~s2_q & s3_q;
        end else begin
            edge_det = s2_q ^ s3_q;
        end
    end

    always_comb begin
        s1_d      = in_port;
        s2_d      = s1_q;
        s3_d      = s2_q;
        irqmask_d = wr_mask ? bus.writedata[DATA_WIDTH-1:0] : irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_ec) begin
`ifdef BIT_CLEAR_EDGE_EN
            edgecap_d = edgecap_q & ~bus.writedata[DATA_WIDTH-1:0];
`else
            edgecap_d = '0;
`endif
        end
        // set is applied after clear so a same-cycle edge is never lost
        edgecap_d = edgecap_d | edge_det;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    always_comb begin
        rd_dat = '0;
        case (bus.address)
            2'd0:    rd_dat[DATA_WIDTH-1:0] = s2_q;
            2'd2:    rd_dat[DATA_WIDTH-1:0] = irqmask_q;
            2'd3:    rd_dat[DATA_WIDTH-1:0] = edgecap_q;
            default: rd_dat = '0;
        endcase
    end

    assign bus.readdata = rd_dat;
    assign bus.irq      = |(edgecap_q & irqmask_q);
endmodule

// File: tb/tb_nios_edge_capture_in.sv
// Scoreboarded bench for nios_edge_capture_in: one rising-edge and one any-edge instance
// share in_port; each read pushes its expected readdata/irq, a negedge monitor checks.
module tb_nios_edge_capture_in;
    localparam int DW = 8;
    localparam bit R = 1'b0;
    localparam bit A = 1'b1;
`ifdef BIT_CLEAR_EDGE_EN
    localparam logic [31:0] CLR_EXP = 32'h80;
`else
    localparam logic [31:0] CLR_EXP = 32'h00;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] in_port = '0;

    nios_edge_capture_in_if bus_r ();
    nios_edge_capture_in_if bus_a ();

    nios_edge_capture_in #(.DATA_WIDTH(DW), .EDGE_TYPE(0)) dut_r (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus_r)
    );

    nios_edge_capture_in #(.DATA_WIDTH(DW), .EDGE_TYPE(2)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus_a)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        bit          sel;
        logic [31:0] d;
        logic        irq;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] act_d;
    logic        act_irq;
    int          n_vec = 0;
    int          n_err = 0;
    int          rd_id = 0;

    task automatic drive(input bit sel, input logic cs, input logic wn,
                         input logic [1:0] a, input logic [31:0] d);
        if (sel) begin
            bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.address = a; bus_a.writedata = d;
        end else begin
            bus_r.chipselect = cs; bus_r.write_n = wn; bus_r.address = a; bus_r.writedata = d;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input bit sel, input logic [1:0] a, input logic [31:0] d);
        drive(sel, 1'b1, 1'b0, a, d);
        idle(1);
        drive(sel, 1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    task automatic rd(input bit sel, input logic [1:0] a, input logic [31:0] d, input logic irq);
        exp_t e;
        e.id = rd_id; e.sel = sel; e.d = d; e.irq = irq;
        rd_id++;
        sb.push_back(e);
        drive(sel, 1'b1, 1'b1, a, 32'h0);
        idle(1);
        drive(sel, 1'b0, 1'b1, 2'd0, 32'h0);
    endtask

    always @(negedge clk) begin
        if ((bus_r.chipselect && bus_r.write_n) || (bus_a.chipselect && bus_a.write_n)) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_read: no expected entry queued");
            end else begin
                mon_e   = sb.pop_front();
                act_d   = mon_e.sel ? bus_a.readdata : bus_r.readdata;
                act_irq = mon_e.sel ? bus_a.irq : bus_r.irq;
                n_vec++;
                if (act_d !== mon_e.d) begin
                    n_err++;
                    $display("FAIL rd%0d_data dut=%0d got %h want %h", mon_e.id, mon_e.sel, act_d, mon_e.d);
                end
                n_vec++;
                if (act_irq !== mon_e.irq) begin
                    n_err++;
                    $display("FAIL rd%0d_irq dut=%0d got %b want %b", mon_e.id, mon_e.sel, act_irq, mon_e.irq);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        drive(R, 1'b0, 1'b1, 2'd0, 32'h0);
        drive(A, 1'b0, 1'b1, 2'd0, 32'h0);
        idle(3);
        reset_n = 1'b1;
        idle(1);
        // state straight out of reset
        rd(R, 2'd0, 32'h00, 1'b0);
        rd(R, 2'd1, 32'h00, 1'b0);
        rd(R, 2'd2, 32'h00, 1'b0);
        rd(R, 2'd3, 32'h00, 1'b0);
        rd(A, 2'd3, 32'h00, 1'b0);
        // two-clock data latency, then three-clock edge capture
        in_port = 8'hA5;
        idle(1);
        rd(R, 2'd0, 32'h00, 1'b0);
        rd(R, 2'd0, 32'hA5, 1'b0);
        rd(R, 2'd3, 32'hA5, 1'b0);
        rd(A, 2'd3, 32'hA5, 1'b0);
        in_port = 8'h00;
        idle(3);
        wr(R, 2'd3, 32'hFF);
        wr(A, 2'd3, 32'hFF);
        rd(R, 2'd3, 32'h00, 1'b0);
        rd(A, 2'd3, 32'h00, 1'b0);
        // writes to data and reserved addresses have no effect
        wr(R, 2'd0, 32'hFF);
        wr(R, 2'd1, 32'hFF);
        rd(R, 2'd0, 32'h00, 1'b0);
        rd(R, 2'd1, 32'h00, 1'b0);
        // rising capture on bit 3, sticky through the fall, masking
        in_port = 8'h08;
        idle(2);
        rd(R, 2'd3, 32'h00, 1'b0);
        rd(R, 2'd3, 32'h08, 1'b0);
        in_port = 8'h00;
        idle(3);
        rd(R, 2'd3, 32'h08, 1'b0);
        wr(R, 2'd2, 32'h08);
        rd(R, 2'd2, 32'h08, 1'b1);
        wr(R, 2'd2, 32'h00);
        rd(R, 2'd3, 32'h08, 1'b0);
        wr(R, 2'd2, 32'h08);
        rd(R, 2'd3, 32'h08, 1'b1);
        // any-edge: falling edge of bit 0 captured only by the any-edge instance
        wr(A, 2'd3, 32'hFF);
        rd(A, 2'd3, 32'h00, 1'b0);
        in_port = 8'h01;
        idle(3);
        wr(A, 2'd3, 32'hFF);
        wr(R, 2'd3, 32'hFF);
        rd(A, 2'd3, 32'h00, 1'b0);
        rd(R, 2'd3, 32'h00, 1'b0);
        in_port = 8'h00;
        idle(3);
        rd(A, 2'd3, 32'h01, 1'b0);
        rd(R, 2'd3, 32'h00, 1'b0);
        // clear-all versus per-bit clear
        in_port = 8'h81;
        idle(3);
        rd(R, 2'd3, 32'h81, 1'b0);
        wr(R, 2'd3, 32'h01);
        rd(R, 2'd3, CLR_EXP, 1'b0);
        in_port = 8'h00;
        idle(3);
        wr(R, 2'd3, 32'hFF);
        rd(R, 2'd3, 32'h00, 1'b0);
        // clear lands on the same edge that sets bit 2
        wr(R, 2'd2, 32'h04);
        in_port = 8'h04;
        idle(2);
        wr(R, 2'd3, 32'hFF);
        rd(R, 2'd3, 32'h04, 1'b1);
        rd(R, 2'd1, 32'h00, 1'b1);
        // asynchronous reset in the middle of a write
        wr(R, 2'd2, 32'hFF);
        in_port = 8'h0F;
        idle(3);
        rd(R, 2'd3, 32'h0F, 1'b1);
        in_port = 8'h00;
        idle(3);
        rd(R, 2'd3, 32'h0F, 1'b1);
        drive(R, 1'b1, 1'b0, 2'd2, 32'h55);
        #2;
        reset_n = 1'b0;
        idle(1);
        drive(R, 1'b0, 1'b1, 2'd0, 32'h0);
        idle(1);
        reset_n = 1'b1;
        rd(R, 2'd2, 32'h00, 1'b0);
        rd(R, 2'd3, 32'h00, 1'b0);
        rd(R, 2'd0, 32'h00, 1'b0);
        // input held high across reset release registers a rising edge
        reset_n = 1'b0;
        in_port = 8'h10;
        idle(2);
        reset_n = 1'b1;
        idle(2);
        rd(R, 2'd3, 32'h00, 1'b0);
        rd(R, 2'd3, 32'h10, 1'b0);
        idle(2);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d reads left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
